vq_dequant_vec: RTL and testbench

//  Streaming vector dequantizer, successor to the fixed-scale 8-element dequantizer in the vector-quantization path.
//  Per element: y = sat((x - zero_point) * scale, rounded and arithmetically right-shifted by shift).

---
 rtl/vq_pkg.sv | 30 +++
 rtl/vq_round_sat.sv | 28 ++
 rtl/vq_dequant_vec.sv | 119 +++++++++++
 tb/tb_vq_dequant_vec.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vq_pkg.sv
// Shared widths, the config/tag bundle that rides with each element, and the
// signed saturation helper used by the dequantize/quantize datapaths.
package vq_pkg;

  localparam int IN_W    = 8;
  localparam int SCALE_W = 16;
  localparam int SH_W    = 5;
  localparam int OUT_W   = 32;
  localparam int PROD_W  = IN_W + 1 + SCALE_W;

  typedef struct packed {
    logic [SCALE_W-1:0]     scale;
    logic signed [IN_W-1:0] zp;
    logic [SH_W-1:0]        shift;
    logic                   last;
  } vq_cfg_t;

  // Clamp a signed value to the range of a width-bit two's complement number.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] value,
                                               input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/vq_round_sat.sv
// Round-half-up arithmetic right shift of a signed product, then saturation
// to the signed output width. Purely combinational.
module vq_round_sat #(
  parameter int P_W   = vq_pkg::PROD_W,
  parameter int SH_W  = vq_pkg::SH_W,
  parameter int OUT_W = vq_pkg::OUT_W
) (
  input  logic signed [P_W-1:0]   p_i,
  input  logic [SH_W-1:0]         shift_i,
  output logic signed [OUT_W-1:0] y_o
);
  import vq_pkg::*;

  logic signed [63:0] ext;
  logic signed [63:0] bias;
  logic signed [63:0] r;

  // 64 bits holds the product plus the largest rounding bias, so shifts past
  // the product width settle cleanly to 0 or -1.
  always_comb begin
    ext  = 64'(p_i);
    bias = '0;
    if (shift_i != '0) bias = 64'sd1 <<< (shift_i - SH_W'(1));
    r    = (ext + bias) >>> shift_i;
    y_o  = OUT_W'(sat_s(r, OUT_W));
  end

endmodule

// File: rtl/vq_dequant_vec.sv
// Streaming vector dequantizer: y = sat(((x - zp) * scale) rounded >>> shift),
// two-stage pipeline with per-vector config captured on the first element.
module vq_dequant_vec #(
  parameter int IN_W    = vq_pkg::IN_W,
  parameter int SCALE_W = vq_pkg::SCALE_W,
  parameter int SH_W    = vq_pkg::SH_W,
  parameter int OUT_W   = vq_pkg::OUT_W,
  parameter int VEC_LEN = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [SCALE_W-1:0] scale_i,
  input  logic [IN_W-1:0]    zero_point_i,
  input  logic [SH_W-1:0]    shift_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [IN_W-1:0]    din_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [OUT_W-1:0]   dout_o,
  output logic               last_o,
  output logic               done_o,
  output logic               busy_o
);
  import vq_pkg::*;

  localparam int P_W   = IN_W + 1 + SCALE_W;
  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  logic [CNT_W-1:0]        in_cnt;
  vq_cfg_t                 cfg_q;
  vq_cfg_t                 cfg_in;
  vq_cfg_t                 s1_cfg;
  logic signed [IN_W-1:0]  s1_x;
  logic                    s1_valid;
  logic                    s2_valid;
  logic                    s1_adv;
  logic                    accept;
  logic signed [IN_W:0]    diff;
  logic signed [P_W-1:0]   d_ext;
  logic signed [P_W-1:0]   s_ext;
  logic signed [P_W-1:0]   prod;
  logic signed [OUT_W-1:0] y;
  logic signed [OUT_W-1:0] dout_q;
  logic                    last_q;
  logic                    done_q;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a stage advances only when the stage below is empty or draining.
  assign s1_adv  = s1_valid && (!s2_valid || ready_i);
  assign ready_o = !rst_i && (!s1_valid || s1_adv);
  assign accept  = valid_i && ready_o;

  // Element 0 takes config from the ports; later elements reuse the latched copy.
  always_comb begin
    cfg_in = cfg_q;
    if (in_cnt == '0) begin
      cfg_in.scale = scale_i;
      cfg_in.zp    = zero_point_i;
      cfg_in.shift = shift_i;
    end
    cfg_in.last = (in_cnt == CNT_W'(VEC_LEN - 1));
  end

  always_comb begin
    diff  = {s1_x[IN_W-1], s1_x} - {s1_cfg.zp[IN_W-1], s1_cfg.zp};
    d_ext = P_W'(diff);
    s_ext = P_W'({1'b0, s1_cfg.scale});
    prod  = d_ext * s_ext;
  end

  vq_round_sat #(
    .P_W   (P_W),
    .SH_W  (SH_W),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .p_i     (prod),
    .shift_i (s1_cfg.shift),
    .y_o     (y)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_cnt   <= '0;
      cfg_q    <= '0;
      s1_cfg   <= '0;
      s1_x     <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      dout_q   <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= s2_valid && ready_i && last_q;
      if (accept) begin
        in_cnt <= cfg_in.last ? '0 : in_cnt + CNT_W'(1);
        if (in_cnt == '0) cfg_q <= cfg_in;
        s1_cfg <= cfg_in;
        s1_x   <= din_i;
      end
      if (accept) s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;
      if (s1_adv) begin
        s2_valid <= 1'b1;
        dout_q   <= y;
        last_q   <= s1_cfg.last;
      end else if (ready_i) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign valid_o = s2_valid;
  assign dout_o  = dout_q;
  assign last_o  = last_q;
  assign done_o  = done_q;
  assign busy_o  = (in_cnt != '0) || s1_valid || s2_valid;

endmodule

// File: tb/tb_vq_dequant_vec.sv
// Directed bench for vq_dequant_vec: main instance (OUT_W=32, VEC_LEN=8) plus a
// narrow single-element instance (OUT_W=16, VEC_LEN=1) for saturation.
module tb_vq_dequant_vec;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_i = 1'b1;

  // main instance
  logic [15:0] scale_i = '0;
  logic [7:0]  zero_point_i = '0;
  logic [4:0]  shift_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [7:0]  din_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] dout_o;
  logic        last_o, done_o, busy_o;

  // narrow instance
  logic [15:0] scale_b = '0;
  logic [7:0]  zp_b = '0;
  logic [4:0]  shift_b = '0;
  logic        valid_b = 1'b0;
  logic        ready_bo;
  logic [7:0]  din_b = '0;
  logic        valid_bo;
  logic        ready_b = 1'b1;
  logic [15:0] dout_b;
  logic        last_b, done_b, busy_b;

  vq_dequant_vec #(.OUT_W(32), .VEC_LEN(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .scale_i(scale_i), .zero_point_i(zero_point_i),
    .shift_i(shift_i), .valid_i(valid_i), .ready_o(ready_o), .din_i(din_i),
    .valid_o(valid_o), .ready_i(ready_i), .dout_o(dout_o), .last_o(last_o),
    .done_o(done_o), .busy_o(busy_o)
  );

  vq_dequant_vec #(.OUT_W(16), .VEC_LEN(1)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .scale_i(scale_b), .zero_point_i(zp_b),
    .shift_i(shift_b), .valid_i(valid_b), .ready_o(ready_bo), .din_i(din_b),
    .valid_o(valid_bo), .ready_i(ready_b), .dout_o(dout_b), .last_o(last_b),
    .done_o(done_b), .busy_o(busy_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [32:0] exp_q[$];
  logic rand_mode = 1'b0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // downstream ready: held high, or 50% random while rand_mode is set
  initial forever begin
    @(posedge clk);
    #1;
    ready_i = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input int val, input bit last);
    exp_q.push_back({last, 32'(val)});
  endtask

  task automatic send(input int x, input int sc, input int zp, input int sh);
    int t;
    logic ok;
    valid_i = 1'b1;
    din_i = 8'(x);
    scale_i = 16'(sc);
    zero_point_i = 8'(zp);
    shift_i = 5'(sh);
    t = 0;
    ok = 1'b0;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = ready_o;
      @(posedge clk);
      t++;
    end
    #1 valid_i = 1'b0;
    check("send_timeout", ok, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy_o) && t < 1000) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_timeout", t < 1000, 1);
  endtask

  task automatic send_b(input int x, input int zp, input int exp);
    valid_b = 1'b1;
    din_b = 8'(x);
    scale_b = 16'hffff;
    zp_b = 8'(zp);
    shift_b = '0;
    @(negedge clk);
    check("b_ready", ready_bo, 1);
    @(posedge clk);
    #1 valid_b = 1'b0;
    @(negedge clk);
    check("b_latency_1", valid_bo, 0);
    @(negedge clk);
    check("b_valid", valid_bo, 1);
    check("b_dout", $signed(dout_b), exp);
    check("b_last", last_b, 1);
    @(negedge clk);
    check("b_done", done_b, 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic done_exp = 1'b0;
  logic held = 1'b0;
  logic [31:0] held_dout;
  logic held_last;
  logic [32:0] e;

  always @(negedge clk) begin
    if (rst_i) begin
      done_exp = 1'b0;
      held = 1'b0;
    end else begin
      check("done_o", done_o, done_exp);
      if (done_o) done_cnt++;
      if (held) begin
        check("hold_valid", valid_o, 1);
        check("hold_dout", dout_o, held_dout);
        check("hold_last", last_o, held_last);
      end
      done_exp = valid_o && ready_i && last_o;
      held = valid_o && !ready_i;
      held_dout = dout_o;
      held_last = last_o;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) check("unexpected_out", valid_o, 0);
        else begin
          e = exp_q.pop_front();
          check("dout", $signed(dout_o), $signed(e[31:0]));
          check("last_o", last_o, e[32]);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  int legacy_in[4]  = '{-3, 1, 127, -128};
  int legacy_out[4] = '{-7224, 2408, 305816, -308224};
  int rnd_in_a[8]   = '{10, 5, -5, 0, 2, 3, 1, -1};
  int rnd_out_a[8]  = '{12, 5, -10, -3, 0, 2, -1, -4};
  int rnd_in_b[8]   = '{5, -5, 10, 0, 1, -1, 127, -128};
  int rnd_out_b[8]  = '{8, -7, 15, 0, 2, -1, 191, -192};
  int big_in[8]     = '{-128, 127, -1, 1, 0, 64, -64, 100};
  int d0;

  initial begin
    // reset state
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_o", valid_o, 0);
    check("rst_dout_o", dout_o, 0);
    check("rst_last_o", last_o, 0);
    check("rst_done_o", done_o, 0);
    check("rst_busy_o", busy_o, 0);
    check("rst_ready_o", ready_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    check("ready_after_rst", ready_o, 1);
    @(posedge clk);
    #1;

    // 1: legacy scale, 2-cycle latency, done after 8th
    d0 = done_cnt;
    for (int k = 0; k < 8; k++) push_exp(legacy_out[k % 4], k == 7);
    send(legacy_in[0], 2408, 0, 0);
    @(negedge clk);
    check("latency_1", valid_o, 0);
    @(negedge clk);
    check("latency_2", valid_o, 1);
    @(posedge clk);
    #1;
    for (int k = 1; k < 8; k++) send(legacy_in[k % 4], 2408, 0, 0);
    drain();
    check("legacy_done_cnt", done_cnt, d0 + 1);

    // 2: zero point and round-half-up, then a shift beyond the product width
    for (int k = 0; k < 8; k++) push_exp(rnd_out_a[k], k == 7);
    for (int k = 0; k < 8; k++) send(rnd_in_a[k], 3, 2, 1);
    for (int k = 0; k < 8; k++) push_exp(rnd_out_b[k], k == 7);
    for (int k = 0; k < 8; k++) send(rnd_in_b[k], 3, 0, 1);
    for (int k = 0; k < 8; k++) push_exp(0, k == 7);
    for (int k = 0; k < 8; k++) send(big_in[k], 65535, 0, 31);
    drain();

    // 4: random backpressure over three ramp vectors
    d0 = done_cnt;
    rand_mode = 1'b1;
    for (int v = 0; v < 3; v++)
      for (int k = 0; k < 8; k++) begin
        push_exp(k * (v + 1), k == 7);
        send(k, v + 1, 0, 0);
      end
    drain();
    rand_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("bp_done_cnt", done_cnt, d0 + 3);

    // 5: mid-vector config changes are ignored
    d0 = done_cnt;
    for (int k = 0; k < 8; k++) begin
      push_exp(5 * (k + 1), k == 7);
      send(k + 1, (k < 4) ? 5 : 7, 0, 0);
    end
    for (int k = 0; k < 8; k++) begin
      push_exp(9 * (k + 1), k == 7);
      send(k + 1, (k == 0) ? 9 : 11, 0, 0);
    end
    drain();
    check("cfg_done_cnt", done_cnt, d0 + 2);

    // 6: reset after five accepted elements
    d0 = done_cnt;
    for (int k = 0; k < 5; k++) begin
      push_exp(k + 1, 1'b0);
      send(k + 1, 1, 0, 0);
    end
    rst_i = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("abort_valid_o", valid_o, 0);
    check("abort_dout_o", dout_o, 0);
    check("abort_last_o", last_o, 0);
    check("abort_done_o", done_o, 0);
    check("abort_busy_o", busy_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    check("abort_ready_o", ready_o, 1);
    check("abort_no_done", done_cnt, d0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      push_exp(2 * k, k == 7);
      send(k, 2, 0, 0);
    end
    drain();
    check("post_abort_done_cnt", done_cnt, d0 + 1);

    // 3: saturation on the 16-bit, single-element instance
    send_b(127, -128, 32767);
    send_b(-128, 127, -32768);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
